// File: rtl/exec_pipe.sv
// Execute stage: one-cycle ALU/shifter with a registered valid/ready output slot.
// Define EXEC_PIPE_MUL_EN to build the iterative shift-add multiplier and its MUL state.
module exec_pipe #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_aluop,
  input  logic                     in_unsig,
  input  logic                     in_selimm,
  input  logic                     in_selshift,
  input  logic [1:0]               in_shiftop,
  input  logic [$clog2(WIDTH)-1:0] in_shiftamt,
  input  logic                     in_mul,
  input  logic [WIDTH-1:0]         in_rega,
  input  logic [WIDTH-1:0]         in_regb,
  input  logic [WIDTH-1:0]         in_imm,
  input  logic [2:0]               in_memctl,
  input  logic [REGW-1:0]          in_regdest,
  input  logic                     in_writereg,
  input  logic                     in_writeov,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_memctl,
  output logic [WIDTH-1:0]         out_regb,
  output logic [REGW-1:0]          out_regdest,
  output logic                     out_writereg,
  output logic [WIDTH-1:0]         out_wbvalue,
  output logic                     out_ov,
  output logic                     busy
);

  logic [WIDTH-1:0]   opb, sum, diff, alu_res, sh_res, sh_sra, ex_res;
  logic [2*WIDTH-1:0] rot_dbl;
  logic               lt, ov_add, ov_sub, ex_ov;
  logic               slot_free, xfer_in, load_now, mul_load, load;
  logic [WIDTH-1:0]   nxt_wb, nxt_rb;
  logic [REGW-1:0]    nxt_rd;
  logic [2:0]         nxt_mem;
  logic               nxt_ov, nxt_wr;

  assign opb    = in_selimm ? in_imm : in_regb;
  assign sum    = in_rega + opb;
  assign diff   = in_rega - opb;
  assign ov_add = (in_rega[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != in_rega[WIDTH-1]);
  assign ov_sub = (in_rega[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != in_rega[WIDTH-1]);
  assign lt     = in_unsig ? (in_rega < opb) : ($signed(in_rega) < $signed(opb));

  always_comb begin
    alu_res = '0;
    case (in_aluop)
      3'd0: alu_res = sum;
      3'd1: alu_res = diff;
      3'd2: alu_res = in_rega & opb;
      3'd3: alu_res = in_rega | opb;
      3'd4: alu_res = in_rega ^ opb;
      3'd5: alu_res = ~(in_rega | opb);
      3'd6: alu_res = {{(WIDTH-1){1'b0}}, lt};
      default: alu_res = opb;
    endcase
  end

  // Rotate via a doubled word: the low half of {b,b} >> n is b rotated right by n.
  assign rot_dbl = {in_regb, in_regb} >> in_shiftamt;
  assign sh_sra  = $signed(in_regb) >>> in_shiftamt;

  always_comb begin
    sh_res = '0;
    case (in_shiftop)
      2'd0: sh_res = in_regb << in_shiftamt;
      2'd1: sh_res = in_regb >> in_shiftamt;
      2'd2: sh_res = sh_sra;
      default: sh_res = rot_dbl[WIDTH-1:0];
    endcase
  end

  assign ex_res    = in_selshift ? sh_res : alu_res;
  assign ex_ov     = ~in_selshift & ~in_unsig &
                     (((in_aluop == 3'd0) & ov_add) | ((in_aluop == 3'd1) & ov_sub));
  assign slot_free = ~out_valid | out_ready;
  assign xfer_in   = in_valid & in_ready;

`ifdef EXEC_PIPE_MUL_EN
  localparam int LOGW = $clog2(WIDTH);
  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    MUL   = 1'b1;
  localparam logic [LOGW:0] NITER = (LOGW+1)'(WIDTH);

  logic [0:0]       state;
  logic [LOGW:0]    iter;
  logic [WIDTH-1:0] mcand, mplier, acc, m_regb;
  logic [REGW-1:0]  m_regdest;
  logic [2:0]       m_memctl;
  logic             m_writereg;
  logic             mul_done;

  assign mul_done = (iter == NITER);
  assign mul_load = (state == MUL) & mul_done & slot_free;
  assign load_now = xfer_in & ~in_mul;
  assign in_ready = ~reset & (state == IDLE) & slot_free;
  assign busy     = (state == MUL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      iter       <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      m_regb     <= '0;
      m_regdest  <= '0;
      m_memctl   <= '0;
      m_writereg <= 1'b0;
    end else if (state == IDLE) begin
      if (xfer_in & in_mul) begin
        state      <= MUL;
        iter       <= '0;
        mcand      <= in_rega;
        mplier     <= in_regb;
        acc        <= '0;
        m_regb     <= in_regb;
        m_regdest  <= in_regdest;
        m_memctl   <= in_memctl;
        m_writereg <= in_writereg;
      end
    end else begin
      // After the last bit the finished product waits here until the slot frees.
      if (!mul_done) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        iter   <= iter + 1'b1;
      end else if (slot_free) begin
        state <= IDLE;
        iter  <= '0;
      end
    end
  end
`else
  assign mul_load = 1'b0;
  assign load_now = xfer_in;
  assign in_ready = ~reset & slot_free;
  assign busy     = 1'b0;
`endif

  assign load = load_now | mul_load;

  always_comb begin
    nxt_wb  = ex_res;
    nxt_ov  = ex_ov;
    nxt_wr  = in_writereg & (~ex_ov | in_writeov);
    nxt_mem = in_memctl;
    nxt_rb  = in_regb;
    nxt_rd  = in_regdest;
`ifdef EXEC_PIPE_MUL_EN
    if (mul_load) begin
      nxt_wb  = acc;
      nxt_ov  = 1'b0;
      nxt_wr  = m_writereg;
      nxt_mem = m_memctl;
      nxt_rb  = m_regb;
      nxt_rd  = m_regdest;
    end
`else
    if (in_mul) begin
      nxt_wb = '0;
      nxt_ov = 1'b1;
      nxt_wr = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_memctl   <= '0;
      out_regb     <= '0;
      out_regdest  <= '0;
      out_writereg <= 1'b0;
      out_wbvalue  <= '0;
      out_ov       <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_memctl   <= nxt_mem;
      out_regb     <= nxt_rb;
      out_regdest  <= nxt_rd;
      out_writereg <= nxt_wr;
      out_wbvalue  <= nxt_wb;
      out_ov       <= nxt_ov;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_pipe.sv
// Scoreboard bench for exec_pipe: directed vectors push expectations, a negedge monitor pops and compares.
module tb_exec_pipe;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, in_valid, in_ready, in_unsig, in_selimm, in_selshift, in_mul;
  logic [2:0]  in_aluop, in_memctl, out_memctl;
  logic [1:0]  in_shiftop;
  logic [4:0]  in_shiftamt, in_regdest, out_regdest;
  logic [31:0] in_rega, in_regb, in_imm, out_regb, out_wbvalue;
  logic        in_writereg, in_writeov, out_valid, out_ready, out_writereg, out_ov, busy;

  logic        v8, rdy8, unsig8, selshift8, ov8_o, wr8_o, valid8_o, busy8;
  logic [2:0]  aluop8, amt8, mem8_o;
  logic [1:0]  shop8;
  logic [7:0]  a8, b8, rb8_o, wb8_o;
  logic [3:0]  rd8_o;

  exec_pipe u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_unsig(in_unsig), .in_selimm(in_selimm), .in_selshift(in_selshift),
    .in_shiftop(in_shiftop), .in_shiftamt(in_shiftamt), .in_mul(in_mul),
    .in_rega(in_rega), .in_regb(in_regb), .in_imm(in_imm), .in_memctl(in_memctl),
    .in_regdest(in_regdest), .in_writereg(in_writereg), .in_writeov(in_writeov),
    .out_valid(out_valid), .out_ready(out_ready), .out_memctl(out_memctl), .out_regb(out_regb),
    .out_regdest(out_regdest), .out_writereg(out_writereg), .out_wbvalue(out_wbvalue),
    .out_ov(out_ov), .busy(busy)
  );

  exec_pipe #(.WIDTH(8), .REGW(4)) u_dut8 (
    .clock(clock), .reset(reset), .in_valid(v8), .in_ready(rdy8),
    .in_aluop(aluop8), .in_unsig(unsig8), .in_selimm(1'b0), .in_selshift(selshift8),
    .in_shiftop(shop8), .in_shiftamt(amt8), .in_mul(1'b0),
    .in_rega(a8), .in_regb(b8), .in_imm(8'h00), .in_memctl(3'd0),
    .in_regdest(4'd0), .in_writereg(1'b1), .in_writeov(1'b0),
    .out_valid(valid8_o), .out_ready(1'b1), .out_memctl(mem8_o), .out_regb(rb8_o),
    .out_regdest(rd8_o), .out_writereg(wr8_o), .out_wbvalue(wb8_o),
    .out_ov(ov8_o), .busy(busy8)
  );

`ifdef EXEC_PIPE_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif

  typedef struct {
    logic [31:0] wb;
    logic        ov;
    logic        wr;
    logic [4:0]  rd;
    logic [2:0]  mem;
    logic [31:0] rb;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tag = 0;
  logic end_req = 1'b0;

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] op, input logic unsig, selimm, selshift, mul,
                       input logic [1:0] sop, input logic [4:0] amt,
                       input logic [31:0] a, b, imm, input logic wov,
                       input logic [31:0] ewb, input logic eov, ewr);
    exp_t e;
    int   n;
    logic [31:0] t;
    tag++;
    t = tag;
    in_valid = 1'b1; in_aluop = op; in_unsig = unsig; in_selimm = selimm;
    in_selshift = selshift; in_mul = mul; in_shiftop = sop; in_shiftamt = amt;
    in_rega = a; in_regb = b; in_imm = imm; in_writeov = wov; in_writereg = 1'b1;
    in_regdest = t[4:0]; in_memctl = t[2:0];
    e.wb = ewb; e.ov = eov; e.wr = ewr; e.rd = t[4:0]; e.mem = t[2:0]; e.rb = b;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 250) begin
      @(negedge clock);
      n++;
    end
    if (in_ready) q32.push_back(e);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic alu(input logic [2:0] op, input logic unsig, selimm,
                     input logic [31:0] a, b, imm, input logic wov,
                     input logic [31:0] ewb, input logic eov, ewr);
    drive(op, unsig, selimm, 1'b0, 1'b0, 2'd0, 5'd0, a, b, imm, wov, ewb, eov, ewr);
  endtask

  task automatic shf(input logic [1:0] sop, input logic [4:0] amt,
                     input logic [31:0] a, b, ewb);
    drive(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, sop, amt, a, b, 32'h0, 1'b0, ewb, 1'b0, 1'b1);
  endtask

  task automatic mulop(input logic [31:0] a, b, prod);
`ifdef EXEC_PIPE_MUL_EN
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd0, a, b, 32'h0, 1'b0, prod, 1'b0, 1'b1);
`else
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd0, a, b, 32'h0, 1'b0, 32'h0 & prod, 1'b1, 1'b0);
`endif
  endtask

  task automatic drive8(input logic [2:0] op, input logic unsig, selshift,
                        input logic [1:0] sop, input logic [2:0] amt,
                        input logic [7:0] a, b, ewb, input logic eov);
    exp_t e;
    v8 = 1'b1; aluop8 = op; unsig8 = unsig; selshift8 = selshift;
    shop8 = sop; amt8 = amt; a8 = a; b8 = b;
    e.wb = {24'h0, ewb}; e.ov = eov; e.wr = ~eov; e.rd = 5'd0; e.mem = 3'd0; e.rb = {24'h0, b};
    q8.push_back(e);
    @(posedge clock);
    #1 v8 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_aluop = '0; in_unsig = 0; in_selimm = 0; in_selshift = 0; in_shiftop = '0;
    in_shiftamt = '0; in_mul = 0; in_rega = '0; in_regb = '0; in_imm = '0;
    in_memctl = '0; in_regdest = '0; in_writereg = 0; in_writeov = 0;
    v8 = 0; aluop8 = '0; unsig8 = 0; selshift8 = 0; shop8 = '0; amt8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // op unsig selimm a b imm wov | wb ov wr
    alu(3'd0, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h0, 0, 32'h80000000, 1, 0);
    alu(3'd0, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h0, 1, 32'h80000000, 1, 1);
    alu(3'd0, 1, 0, 32'h7FFFFFFF, 32'h1, 32'h0, 0, 32'h80000000, 0, 1);
    alu(3'd1, 0, 0, 32'h80000000, 32'h1, 32'h0, 0, 32'h7FFFFFFF, 1, 0);
    alu(3'd2, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 0, 32'h00F000F0, 0, 1);
    alu(3'd3, 0, 1, 32'h12340000, 32'hFFFFFFFF, 32'h00005678, 0, 32'h12345678, 0, 1);
    alu(3'd4, 0, 0, 32'hAAAAAAAA, 32'hFFFF0000, 32'h0, 0, 32'h5555AAAA, 0, 1);
    alu(3'd5, 0, 0, 32'h0F0F0000, 32'h000000F0, 32'h0, 0, 32'hF0F0FF0F, 0, 1);
    alu(3'd6, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 32'h1, 0, 1);
    alu(3'd6, 1, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 32'h0, 0, 1);
    alu(3'd7, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 32'hDEADBEEF, 0, 1);

    // sop amt a b | wb  (a=0x7FFFFFFF with aluop add must not raise overflow on a shift)
    shf(2'd3, 5'd1,  32'h0, 32'h00000001, 32'h80000000);
    shf(2'd2, 5'd31, 32'h0, 32'h80000000, 32'hFFFFFFFF);
    shf(2'd0, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h00000001);
    shf(2'd0, 5'd4,  32'h0, 32'h8000000F, 32'h000000F0);
    shf(2'd1, 5'd31, 32'h0, 32'h80000000, 32'h00000001);
    shf(2'd3, 5'd0,  32'h0, 32'h12345678, 32'h12345678);
    shf(2'd3, 5'd8,  32'h0, 32'h12345678, 32'h78123456);

    mulop(32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD);
    alu(3'd0, 0, 0, 32'h5, 32'h6, 32'h0, 0, 32'hB, 0, 1);

    // downstream stall, then release and back-to-back issue
    repeat (2) @(posedge clock);
    #1 out_ready = 1'b0;
    alu(3'd0, 0, 0, 32'h5, 32'h7, 32'h0, 0, 32'hC, 0, 1);
    fork
      alu(3'd1, 0, 0, 32'h3, 32'h5, 32'h0, 0, 32'hFFFFFFFE, 0, 1);
      begin
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    alu(3'd4, 0, 0, 32'h1, 32'h3, 32'h0, 0, 32'h2, 0, 1);
    alu(3'd3, 0, 0, 32'h100, 32'h1, 32'h0, 0, 32'h101, 0, 1);

    // reset part-way through a multiply, then a multiply that must complete
    mulop(32'h12345678, 32'h9, 32'hA3D70A38);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    mulop(32'h00010001, 32'h00010001, 32'h00020001);

    // op unsig selshift sop amt a b | wb ov
    drive8(3'd6, 1, 0, 2'd0, 3'd0, 8'h80, 8'h01, 8'h00, 0);
    drive8(3'd6, 0, 0, 2'd0, 3'd0, 8'h80, 8'h01, 8'h01, 0);
    drive8(3'd0, 0, 0, 2'd0, 3'd0, 8'h7F, 8'h01, 8'h80, 1);
    drive8(3'd0, 0, 1, 2'd3, 3'd1, 8'h00, 8'h01, 8'h80, 0);

    repeat (40) @(posedge clock);
    #1 end_req = 1'b1;
    repeat (5) @(posedge clock);
    $display("FAIL end_of_run: monitor did not close the run");
    $fatal(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] got, exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  logic         reset_prev = 1'b0;
  logic         hold_prev = 1'b0;
  logic [127:0] hold_val;
  logic         mul_pending = 1'b0;
  int           mul_cnt = 0;
  int           stuck = 0;
  exp_t         e;

  always @(negedge clock) begin
    if (reset) begin
      chk("reset_in_ready", {127'h0, in_ready}, 128'h0);
      q32.delete();
      q8.delete();
      mul_pending = 1'b0;
      hold_prev = 1'b0;
      stuck = 0;
    end else begin
      if (reset_prev)
        chk("post_reset", {out_valid, busy, in_ready, out_wbvalue, out_ov, out_writereg,
                           out_regb, out_regdest, out_memctl, valid8_o},
                          {1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 5'h0, 3'h0, 1'b0});

      if (mul_pending) begin
        mul_cnt++;
        if (out_valid) begin
          chk("mul_latency", 128'(mul_cnt), 128'(MUL_LAT));
          mul_pending = 1'b0;
        end else if (mul_cnt > 200) begin
          chk("mul_timeout", 128'(mul_cnt), 128'(MUL_LAT));
          mul_pending = 1'b0;
        end else begin
          chk("mul_busy_stall", {126'h0, busy, in_ready}, 128'h2);
        end
      end
      if (in_valid && in_ready && in_mul) begin
        mul_pending = 1'b1;
        mul_cnt = 0;
      end

      if (hold_prev)
        chk("hold_stable", {out_valid, out_wbvalue, out_ov, out_writereg, out_regb, out_regdest, out_memctl},
                           hold_val);
      hold_prev = out_valid && !out_ready;
      if (hold_prev) begin
        chk("stall_in_ready", {127'h0, in_ready}, 128'h0);
        hold_val = {out_valid, out_wbvalue, out_ov, out_writereg, out_regb, out_regdest, out_memctl};
      end

      if (out_valid && out_ready) begin
        if (q32.size() == 0) begin
          chk("unexpected_out32", {96'h0, out_wbvalue}, 128'h0 - 1);
        end else begin
          e = q32.pop_front();
          chk("out32", {out_wbvalue, out_ov, out_writereg, out_regdest, out_memctl, out_regb},
                       {e.wb, e.ov, e.wr, e.rd, e.mem, e.rb});
        end
      end

      if (valid8_o) begin
        if (q8.size() == 0) begin
          chk("unexpected_out8", {120'h0, wb8_o}, 128'h0 - 1);
        end else begin
          e = q8.pop_front();
          chk("out8", {wb8_o, ov8_o, wr8_o, rb8_o}, {e.wb[7:0], e.ov, e.wr, e.rb[7:0]});
        end
      end
      if (v8) chk("in_ready8", {127'h0, rdy8}, 128'h1);

      if (in_valid && !in_ready) stuck++;
      else stuck = 0;
      if (stuck == 200) chk("issue_timeout", 128'(stuck), 128'h0);

      if (end_req) begin
        chk("drain", {64'(q32.size()), 64'(q8.size())}, 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
    reset_prev = reset;
  end

endmodule

// File: doc/exec_pipe.md
EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (legal 8..64, power of two).
REQ-002 SHALL have parameter REGW, default 5, destination register index width.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream operation present.
REQ-006 SHALL have port in_ready  output  1  block accepts operation this cycle.
REQ-007 SHALL have port in_aluop  input  3  0 add,1 sub,2 and,3 or,4 xor,5 nor,6 slt,7 pass-b.
REQ-008 SHALL have port in_unsig  input  1  unsigned compare/no overflow.
REQ-009 SHALL have port in_selimm  input  1  ALU operand b = in_imm instead of in_regb.
REQ-010 SHALL have port in_selshift  input  1  result from shifter instead of ALU.
REQ-011 SHALL have port in_shiftop  input  2  0 sll,1 srl,2 sra,3 ror; source in_regb.
REQ-012 SHALL have port in_shiftamt  input  log2(WIDTH)  shift distance.
REQ-013 SHALL have port in_mul  input  1  iterative multiply, low WIDTH bits of rega*regb.
REQ-014 SHALL have port in_rega/in_regb/in_imm  input  WIDTH each  operands.
REQ-015 SHALL have port in_memctl  input  3  {readmem,writemem,selwsource}, passed through.
REQ-016 SHALL have port in_regdest  input  REGW  destination; in_writereg input 1; in_writeov input 1 write despite overflow.
REQ-017 SHALL have port out_valid  output  1; out_ready  input  1  downstream accept.
REQ-018 SHALL have ports out_memctl 3, out_regb WIDTH, out_regdest REGW, out_writereg 1, out_wbvalue WIDTH, out_ov 1  registered results.
REQ-019 SHALL have port busy  output  1  high while multiplier iterates; drives fetch stall.

Function
REQ-020 SHALL use states IDLE and MUL; transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-021 SHALL drive in_ready = (state==IDLE) & (~out_valid | out_ready).
REQ-022 Non-multiply transfer in SHALL load output register next edge: out_valid=1, one-cycle latency, full throughput.
REQ-023 Overflow SHALL flag only signed add/sub (in_unsig=0); out_ov = flag; out_writereg = in_writereg & (~flag | in_writeov).
REQ-024 slt SHALL yield 1/0 in bit 0, signed unless in_unsig; shifts by 0 SHALL return in_regb unchanged; ror wraps bits.
REQ-025 Multiply transfer in SHALL latch all fields, enter MUL, iterate one shift-add bit per cycle for WIDTH cycles; result modulo 2^WIDTH, out_ov=0.
REQ-026 After last iteration SHALL load output register when slot free (~out_valid | out_ready), then return to IDLE; else stay MUL holding result.
REQ-027 Multiply latency SHALL be WIDTH+1 cycles transfer-in to out_valid when downstream never stalls.
REQ-028 Output register SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-029 Transfer out without same-cycle load SHALL clear out_valid; simultaneous out and in SHALL replace contents, out_valid stays 1.
REQ-030 busy SHALL equal (state==MUL).

Reset
REQ-031 reset SHALL force state IDLE, iteration counter 0, out_valid 0, all out_* 0, busy 0; reset mid-multiply SHALL abandon the operation.
REQ-032 in_ready SHALL be 0 during the reset cycle and 1 the cycle after.

Configuration
REQ-033 Macro EXEC_PIPE_MUL_EN defined SHALL compile the multiplier and MUL state as specified.
REQ-034 Without EXEC_PIPE_MUL_EN, in_mul SHALL be treated as one-cycle op: out_wbvalue 0, out_writereg 0, out_ov 1; busy tied 0.

Verification
REQ-035 WIDTH=32: add 0x7FFFFFFF+1, in_writeov=0 -> next cycle out_ov=1, out_writereg=0, out_wbvalue 0x80000000.
REQ-036 ror regb=0x00000001 amt=1 -> out_wbvalue 0x80000000; sra 0x80000000 amt=31 -> 0xFFFFFFFF.
REQ-037 MUL_EN, mul 0xFFFFFFFF*3 -> busy 32 cycles, in_ready 0, out_valid at cycle 33, out_wbvalue 0xFFFFFFFD.
REQ-038 out_ready=0 for 5 cycles after valid result -> out_* stable, in_ready 0; release -> back-to-back ops one per cycle.
REQ-039 reset pulse at MUL cycle 10 -> next cycle out_valid 0, busy 0, following op completes normally.
REQ-040 WIDTH=8, REGW=4, slt unsigned 0x80 vs 0x01 -> 0; signed -> 1.
